// File: rtl/frame_sync_1010.sv
// frame_sync_1010
//   Frame synchroniser that sits behind the overlapping Moore 1010 detector.
//   It locks onto a marker that repeats every FRAME_LEN bits, confirms the
//   alignment over LOCK_CNT markers, and then flywheels through up to
//   MISS_CNT-1 consecutive missed markers before dropping back to hunting.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   det          in   one-clock hit pulse from the 1010 detector
//   locked       out  high while aligned (LOCKED state)
//   frame_start  out  one-clock strobe per frame boundary while locked
//   bit_pos      out  bit index within the frame, 0 while hunting
//   sync_err     out  one-clock strobe per missed marker slot while locked
//   err_count    out  saturating count of sync_err strobes
//   stray_count  out  saturating count of off-slot markers while locked
//
// Build option
//   FRAME_SYNC_STRAY_EN  when defined, builds the stray-marker counter;
//                        otherwise stray_count is tied to zero.
//
// state  | meaning
// HUNT   | no alignment, waiting for any marker
// VERIFY | tentative alignment, counting on-slot markers
// LOCKED | aligned, emitting frame_start, tolerating isolated misses

module frame_sync_1010 #(
  parameter int FRAME_LEN = 8,
  parameter int LOCK_CNT  = 3,
  parameter int MISS_CNT  = 2,
  parameter int ERR_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         det,
  output logic                         locked,
  output logic                         frame_start,
  output logic [$clog2(FRAME_LEN)-1:0] bit_pos,
  output logic                         sync_err,
  output logic [ERR_W-1:0]             err_count,
  output logic [ERR_W-1:0]             stray_count
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = $clog2(MISS_CNT + 1);

  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [XW-1:0] MISS_LAST = XW'(MISS_CNT - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [MW-1:0]    match_q, match_d;
  logic [XW-1:0]    miss_q, miss_d;
  logic             fs_q, fs_d;
  logic             se_q, se_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [PW-1:0]    pos_next;
  logic             slot;

  assign slot     = (pos_q == '0);
  assign pos_next = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HUNT;
      pos_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      fs_q    <= 1'b0;
      se_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      fs_q    <= fs_d;
      se_q    <= se_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    match_d = match_q;
    miss_d  = miss_q;
    fs_d    = 1'b0;
    se_d    = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_HUNT: begin
        if (det) begin
          // The acquiring marker occupies slot 0, so the next cycle is bit 1.
          pos_d   = PW'(1);
          match_d = MW'(1);
          miss_d  = '0;
          if (LOCK_CNT == 1) begin
            state_d = ST_LOCKED;
            fs_d    = 1'b1;
          end else begin
            state_d = ST_VERIFY;
          end
        end
      end

      ST_VERIFY: begin
        pos_d = pos_next;
        if (slot) begin
          if (det) begin
            match_d = match_q + MW'(1);
            if (match_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
              fs_d    = 1'b1;
            end
          end else begin
            state_d = ST_HUNT;
            pos_d   = '0;
            match_d = '0;
          end
        end
      end

      ST_LOCKED: begin
        pos_d = pos_next;
        if (slot) begin
          if (det) begin
            miss_d = '0;
            fs_d   = 1'b1;
          end else begin
            se_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (miss_q == MISS_LAST) begin
              state_d = ST_HUNT;
              pos_d   = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              // Flywheel: keep the frame timing through a tolerated miss.
              miss_d = miss_q + XW'(1);
              fs_d   = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
        pos_d   = '0;
        match_d = '0;
        miss_d  = '0;
      end
    endcase
  end

`ifdef FRAME_SYNC_STRAY_EN
  logic [ERR_W-1:0] stray_q, stray_d;

  always_comb begin
    stray_d = stray_q;
    if ((state_q == ST_LOCKED) && !slot && det && (stray_q != '1))
      stray_d = stray_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stray_q <= '0;
    else        stray_q <= stray_d;
  end

  assign stray_count = stray_q;
`else
  assign stray_count = '0;
`endif

  assign locked      = (state_q == ST_LOCKED);
  assign frame_start = fs_q;
  assign sync_err    = se_q;
  assign err_count   = err_q;
  assign bit_pos     = (state_q == ST_HUNT) ? '0 : pos_q;

endmodule

// File: tb/tb_frame_sync_1010.sv
// Testbench for frame_sync_1010 with default parameters.
// A timeline model (cycles since acquisition, marker tallies) predicts every
// output; a compare process checks it each falling edge, and directed
// scenarios add literal expectations at the key cycles.

module tb_frame_sync_1010;

  localparam int FL    = 8;
  localparam int LC    = 3;
  localparam int MC    = 2;
  localparam int EW    = 8;
  localparam int CMAX  = (1 << EW) - 1;
`ifdef FRAME_SYNC_STRAY_EN
  localparam bit STRAY = 1'b1;
`else
  localparam bit STRAY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          det = 1'b0;
  logic          locked, frame_start, sync_err;
  logic [2:0]    bit_pos;
  logic [EW-1:0] err_count, stray_count;

  int checks = 0;
  int errors = 0;

  frame_sync_1010 #(.FRAME_LEN(FL), .LOCK_CNT(LC), .MISS_CNT(MC), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .det(det), .locked(locked),
    .frame_start(frame_start), .bit_pos(bit_pos), .sync_err(sync_err),
    .err_count(err_count), .stray_count(stray_count)
  );

  always #5 clk = ~clk;

  // Model: while aligned, "age" counts cycles since the acquiring marker;
  // a slot is any age that is a multiple of FL.
  bit m_hunting = 1'b1;
  bit m_locked  = 1'b0;
  int m_age     = 0;
  int m_hits    = 0;
  int m_misses  = 0;
  int e_fs      = 0;
  int e_se      = 0;
  int e_err     = 0;
  int e_stray   = 0;
  int e_pos     = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hunting = 1'b1; m_locked = 1'b0; m_age = 0; m_hits = 0; m_misses = 0;
      e_fs = 0; e_se = 0; e_err = 0; e_stray = 0; e_pos = 0;
    end else begin
      e_fs = 0;
      e_se = 0;
      if (m_hunting) begin
        if (det) begin
          m_hunting = 1'b0;
          m_age     = 1;
          m_hits    = 1;
          m_misses  = 0;
          if (m_hits >= LC) begin m_locked = 1'b1; e_fs = 1; end
        end
      end else begin
        if (m_age % FL == 0) begin
          if (!m_locked) begin
            if (det) begin
              m_hits++;
              if (m_hits == LC) begin m_locked = 1'b1; m_misses = 0; e_fs = 1; end
            end else m_hunting = 1'b1;
          end else if (det) begin
            m_misses = 0;
            e_fs = 1;
          end else begin
            e_se = 1;
            if (e_err < CMAX) e_err++;
            m_misses++;
            if (m_misses == MC) begin m_hunting = 1'b1; m_locked = 1'b0; end
            else e_fs = 1;
          end
        end else if (m_locked && det && STRAY) begin
          if (e_stray < CMAX) e_stray++;
        end
        m_age++;
      end
      e_pos = m_hunting ? 0 : (m_age % FL);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_locked", int'(locked), int'(m_locked));
    check("cmp_frame_start", int'(frame_start), e_fs);
    check("cmp_sync_err", int'(sync_err), e_se);
    check("cmp_bit_pos", int'(bit_pos), e_pos);
    check("cmp_err_count", int'(err_count), e_err);
    check("cmp_stray_count", int'(stray_count), e_stray);
  end

  // Present det for one cycle; returns 1 ns after the capturing edge.
  task automatic step(input logic d);
    det = d;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      det = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_locked", int'(locked), 0);
      check("rst_fs", int'(frame_start), 0);
      check("rst_se", int'(sync_err), 0);
      check("rst_pos", int'(bit_pos), 0);
      check("rst_err", int'(err_count), 0);
    end
    det = 1'b0;
    reset = 1'b1;
    gap(3);

    // Acquire: markers at t, t+8, t+16.
    step(1'b1);
    check("acq_pos1", int'(bit_pos), 1);
    gap(7); step(1'b1);
    check("acq_not_locked", int'(locked), 0);
    gap(7); step(1'b1);
    check("acq_locked", int'(locked), 1);
    check("acq_fs", int'(frame_start), 1);
    check("acq_pos", int'(bit_pos), 1);
    gap(7); step(1'b1);
    check("acq_fs2", int'(frame_start), 1);

    // One miss: flywheel.
    gap(7); step(1'b0);
    check("fly_se", int'(sync_err), 1);
    check("fly_fs", int'(frame_start), 1);
    check("fly_locked", int'(locked), 1);
    check("fly_err", int'(err_count), 1);

    // Strays at pos 2 and 5, then an on-slot hit that clears the miss.
    step(1'b0); step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0); step(1'b0);
    step(1'b1);
    check("stray_count", int'(stray_count), STRAY ? 2 : 0);
    check("hit_fs", int'(frame_start), 1);
    check("hit_se", int'(sync_err), 0);
    check("hit_locked", int'(locked), 1);

    // Two consecutive misses drop lock.
    gap(7); step(1'b0);
    check("miss1_locked", int'(locked), 1);
    check("miss1_err", int'(err_count), 2);
    gap(7); step(1'b0);
    check("loss_locked", int'(locked), 0);
    check("loss_se", int'(sync_err), 1);
    check("loss_fs", int'(frame_start), 0);
    check("loss_err", int'(err_count), 3);
    check("loss_pos", int'(bit_pos), 0);

    // VERIFY failure, then immediate re-acquisition.
    gap(2);
    step(1'b1); step(1'b0); step(1'b0); step(1'b1);
    gap(4); step(1'b0);
    check("vfail_locked", int'(locked), 0);
    check("vfail_pos", int'(bit_pos), 0);
    step(1'b1);
    check("reacq_pos", int'(bit_pos), 1);
    gap(7); step(1'b1);
    gap(7); step(1'b1);
    check("relock", int'(locked), 1);
    gap(3);

    // Asynchronous reset between clock edges.
    reset = 1'b0;
    #1;
    check("arst_locked", int'(locked), 0);
    check("arst_pos", int'(bit_pos), 0);
    check("arst_err", int'(err_count), 0);
    check("arst_stray", int'(stray_count), 0);
    for (int i = 0; i < 3; i++) begin
      det = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    det = 1'b0;
    reset = 1'b1;
    gap(10);
    check("hunt_wait_locked", int'(locked), 0);
    check("hunt_wait_pos", int'(bit_pos), 0);
    step(1'b1);
    check("post_rst_acq_pos", int'(bit_pos), 1);
    gap(4);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sync_1010.md
Name: frame_sync_1010

Overview:
- Downstream consumer of the overlapping Moore 1010 detector's one-cycle hit pulse `d`.
- The serial stream carries a 1010 sync marker every FRAME_LEN bits, one bit per clock.
- Block acquires frame alignment, confirms it over LOCK_CNT markers, then flywheels through tolerated misses.
- Outputs a lock flag, per-frame start strobe, bit position, and a saturating sync-error count.

Parameters:
- FRAME_LEN, 8, bits per frame (marker spacing in clocks); must be >= 4.
- LOCK_CNT, 3, consecutive on-slot markers, including the acquiring one, needed to declare lock; >= 1.
- MISS_CNT, 2, consecutive missed slots while locked that force loss of lock; >= 1.
- ERR_W, 8, width of sync-error and stray counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- det  input  1  synchronous pulse from the 1010 detector; one clock per detected marker.
- locked  output  1  high while in LOCKED state.
- frame_start  output  1  one-clock strobe per frame boundary while locked.
- bit_pos  output  $clog2(FRAME_LEN)  current bit index in frame; 0 in HUNT.
- sync_err  output  1  one-clock strobe per missed slot while locked.
- err_count  output  ERR_W  saturating count of sync_err strobes since reset.
- stray_count  output  ERR_W  saturating count of off-slot markers (see Optional Feature).

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low.
  - reset=0 immediately clears state to HUNT, with pos=0, match=0, miss=0.
  - All outputs go to 0 with no clock edge required.
- States: HUNT, VERIFY, LOCKED; encoded in a registered FSM.
- pos counter: in VERIFY/LOCKED, pos increments mod FRAME_LEN every clock. The slot is the cycle in which pos==0.
- HUNT:
  - det=1 -> VERIFY next clock, pos<=1, match<=1.
  - If LOCK_CNT==1, go directly to LOCKED instead.
  - det=0 -> stay in HUNT.
- VERIFY:
  - Slot with det=1: match<=match+1. If match+1==LOCK_CNT, go to LOCKED and pulse frame_start next clock.
  - Slot with det=0: go to HUNT next clock, match<=0, pos<=0.
  - det=1 off-slot: ignored, no re-alignment.
- LOCKED:
  - Slot with det=1: miss<=0; frame_start=1 next clock.
  - Slot with det=0: sync_err=1 next clock; err_count++ (saturates at 2^ERR_W-1); miss<=miss+1.
    - If miss+1==MISS_CNT: go to HUNT, locked=0 next clock, no frame_start.
    - Otherwise stay in LOCKED with frame_start=1 next clock (flywheel).
  - det=1 off-slot: ignored for alignment.
- All outputs are registered; every strobe appears exactly one clock after its slot cycle.
- locked is high exactly when state==LOCKED.
- bit_pos equals pos in VERIFY/LOCKED and 0 in HUNT.
- Re-acquisition: a det in the first HUNT cycle after dropping out of VERIFY or LOCKED is accepted as a new acquisition.
- Counters never wrap; they hold at maximum. Only reset clears err_count and stray_count.

Optional Feature:
- Macro FRAME_SYNC_STRAY_EN.
- Defined:
  - Each det=1 on a non-slot cycle while LOCKED increments stray_count (saturating).
  - Alignment behaviour is unchanged.
- Undefined:
  - No stray logic is built.
  - stray_count is tied to 0.

Test Plan:
- Reset: hold reset=0 for 3 clocks with random det -> locked=0, frame_start=0, sync_err=0, bit_pos=0, err_count=0 throughout.
- Acquire (FRAME_LEN=8, LOCK_CNT=3): det at cycles t, t+8, t+16 -> locked=1 and frame_start=1 at t+17; frame_start again at t+25 with det at t+24.
- VERIFY failure: det at t, det at t+3, no det at t+8 -> back in HUNT at t+9, locked never 1; det at t+9 re-acquires with bit_pos=1 at t+10.
- Flywheel and loss (MISS_CNT=2):
  - Locked; miss one slot -> sync_err=1, frame_start=1, locked stays 1, err_count=1.
  - Next slot hit -> miss cleared.
  - Then two consecutive misses -> locked=0 the clock after the second miss; err_count=3.
- Async reset mid-LOCKED: drop reset between clock edges -> locked, bit_pos, err_count are 0 before the next rising edge; after release, HUNT waits for det.
- With FRAME_SYNC_STRAY_EN: while locked, det at pos=2 and pos=5 -> stray_count=2, lock unaffected. Without the macro -> stray_count stays 0.
